wb_buffer: RTL and testbench

WB_BUFFER -- requirements
Module: wb_buffer

---
 rtl/wb_buffer.sv | 174 +++++++++++++++++
 tb/tb_wb_buffer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_buffer.sv
// Write-back buffer: a circular queue of evicted dirty lines drained to memory,
// with coalescing of repeat evictions and a lookup port for pending cache misses.
module wb_buffer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int WB_DEPTH   = 4
) (
  input  logic                          aclk_i,
  input  logic                          arstn_i,
  input  logic                          push_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0]         data_i,
  output logic                          ready_o,
  input  logic [ADDR_WIDTH-1:0]         lookup_addr_i,
  output logic                          lookup_hit_o,
  output logic                          mem_valid_o,
  output logic [ADDR_WIDTH-1:0]         mem_addr_o,
  output logic [DATA_WIDTH-1:0]         mem_data_o,
  input  logic                          mem_ready_i,
  output logic [$clog2(WB_DEPTH):0]     count_o,
  output logic                          overflow_o
);

  localparam int LINE_OFS = $clog2(DATA_WIDTH/8);
  localparam int LA_W     = ADDR_WIDTH - LINE_OFS;
  localparam int PTR_W    = $clog2(WB_DEPTH);
  localparam int CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(WB_DEPTH);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  state_e                  state_q, state_d;
  logic [WB_DEPTH-1:0]     valid_q, valid_d;
  logic [LA_W-1:0]         addr_q [WB_DEPTH];
  logic [LA_W-1:0]         addr_d [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   data_q [WB_DEPTH];
  logic [DATA_WIDTH-1:0]   data_d [WB_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic                    mem_valid_q, mem_valid_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_data_q, mem_data_d;
  logic                    overflow_q, overflow_d;

  logic [LA_W-1:0]         push_line, look_line;
  logic                    coal_match, lookup_hit, push_new, xfer;
  logic [PTR_W-1:0]        coal_idx;

  generate
    if (LINE_OFS > 0) begin : g_ofs
      logic unused_ofs;
      assign unused_ofs = ^{addr_i[LINE_OFS-1:0], lookup_addr_i[LINE_OFS-1:0]};
    end
  endgenerate

  // The entry being sent (rd_ptr in SEND) is frozen, so it never coalesces.
  always_comb begin
    push_line  = addr_i[ADDR_WIDTH-1:LINE_OFS];
    look_line  = lookup_addr_i[ADDR_WIDTH-1:LINE_OFS];
    coal_match = 1'b0;
    coal_idx   = '0;
    lookup_hit = 1'b0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      if (valid_q[i] && addr_q[i] == look_line) lookup_hit = 1'b1;
      if (valid_q[i] && addr_q[i] == push_line &&
          !(state_q == ST_SEND && rd_ptr_q == PTR_W'(i))) begin
        coal_match = 1'b1;
        coal_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    overflow_d  = overflow_q;
    push_new    = 1'b0;
    xfer        = mem_valid_q && mem_ready_i;

    if (xfer) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    // Fullness is judged on the registered count: a same-cycle completion frees nothing.
    if (push_i) begin
      if (coal_match) begin
        data_d[coal_idx] = data_i;
      end else if (count_q < DEPTH_C) begin
        valid_d[wr_ptr_q] = 1'b1;
        addr_d[wr_ptr_q]  = push_line;
        data_d[wr_ptr_q]  = data_i;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        push_new          = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    if (push_new && !xfer)      count_d = count_q + CNT_W'(1);
    else if (!push_new && xfer) count_d = count_q - CNT_W'(1);

    // Loading from the _d arrays lets a same-cycle write reach the memory port.
    case (state_q)
      ST_IDLE: begin
        if (count_q != '0) begin
          state_d     = ST_SEND;
          mem_valid_d = 1'b1;
          mem_addr_d  = ADDR_WIDTH'(addr_d[rd_ptr_q]) << LINE_OFS;
          mem_data_d  = data_d[rd_ptr_q];
        end
      end
      ST_SEND: begin
        if (xfer) begin
          if (count_d != '0) begin
            mem_addr_d = ADDR_WIDTH'(addr_d[rd_ptr_d]) << LINE_OFS;
            mem_data_d = data_d[rd_ptr_d];
          end else begin
            state_d     = ST_IDLE;
            mem_valid_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q     <= ST_IDLE;
      valid_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      overflow_q  <= overflow_d;
    end
  end

  // Entry payload is qualified by valid_q, so it carries no reset.
  always_ff @(posedge aclk_i) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign ready_o      = (count_q < DEPTH_C) || coal_match;
  assign lookup_hit_o = lookup_hit;
  assign mem_valid_o  = mem_valid_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_wb_buffer.sv
// Self-checking bench for wb_buffer: a scoreboard of expected memory writes
// filled on push and consumed at each completed handshake.
module tb_wb_buffer;

  logic        aclk_i = 1'b0;
  logic        arstn_i;
  logic        push_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic        ready_o;
  logic [31:0] lookup_addr_i;
  logic        lookup_hit_o;
  logic        mem_valid_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_ready_i;
  logic [2:0]  count_o;
  logic        overflow_o;

  wb_buffer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .WB_DEPTH(4)) dut (
    .aclk_i(aclk_i), .arstn_i(arstn_i), .push_i(push_i), .addr_i(addr_i),
    .data_i(data_i), .ready_o(ready_o), .lookup_addr_i(lookup_addr_i),
    .lookup_hit_o(lookup_hit_o), .mem_valid_o(mem_valid_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .count_o(count_o),
    .overflow_o(overflow_o)
  );

  always #5 aclk_i = ~aclk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_wr     = 0;
  logic [63:0] sb [$];
  int wr_cyc [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  always @(posedge aclk_i) cyc++;

  // Monitor: handshake seen between edges completes at the next rising edge.
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;
  always @(negedge aclk_i) begin
    if (arstn_i && prev_stall) begin
      check("hold_valid", {63'd0, mem_valid_o}, 64'd1);
      check("hold_addr", {32'd0, mem_addr_o}, {32'd0, prev_addr});
      check("hold_data", {32'd0, mem_data_o}, {32'd0, prev_data});
    end
    prev_stall = arstn_i && mem_valid_o && !mem_ready_i;
    prev_addr  = mem_addr_o;
    prev_data  = mem_data_o;
    if (arstn_i && mem_valid_o && mem_ready_i) begin
      n_wr++;
      wr_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        check("unexpected_write", {32'd0, mem_addr_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [63:0] e;
        e = sb.pop_front();
        check("wr_addr", {32'd0, mem_addr_o}, {32'd0, e[63:32]});
        check("wr_data", {32'd0, mem_data_o}, {32'd0, e[31:0]});
      end
    end
  end

  task automatic tick();
    @(posedge aclk_i);
    #1;
  endtask

  // mode: 0 new entry, 1 coalesce into newest matching entry, 2 dropped
  task automatic do_push(input logic [31:0] a, input logic [31:0] d, input int mode);
    push_i = 1'b1;
    addr_i = a;
    data_i = d;
    if (mode == 0) sb.push_back({a, d});
    else if (mode == 1) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i][63:32] == a) begin
          sb[i][31:0] = d;
          break;
        end
      end
    end
    tick();
    push_i = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    mem_ready_i = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      tick();
      if (sb.size() == 0 && !mem_valid_o) done = 1;
    end
    check("drain_done", {63'd0, done}, 64'd1);
    check("drain_count", {61'd0, count_o}, 64'd0);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"}, {63'd0, ready_o}, 64'd1);
    check({pfx, "_valid"}, {63'd0, mem_valid_o}, 64'd0);
    check({pfx, "_count"}, {61'd0, count_o}, 64'd0);
    check({pfx, "_ovf"}, {63'd0, overflow_o}, 64'd0);
    check({pfx, "_hit"}, {63'd0, lookup_hit_o}, 64'd0);
    check({pfx, "_addr"}, {32'd0, mem_addr_o}, 64'd0);
    check({pfx, "_data"}, {32'd0, mem_data_o}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    arstn_i = 1'b0; push_i = 1'b0; addr_i = '0; data_i = '0;
    lookup_addr_i = '0; mem_ready_i = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(posedge aclk_i);
    #1 arstn_i = 1'b1;
    tick();

    // Single push, one-cycle latency to mem_valid_o
    mem_ready_i = 1'b1;
    do_push(32'h100, 32'hA5A5A5A5, 0);
    check("single_cnt1", {61'd0, count_o}, 64'd1);
    check("single_nv", {63'd0, mem_valid_o}, 64'd0);
    tick();
    check("single_v", {63'd0, mem_valid_o}, 64'd1);
    check("single_addr", {32'd0, mem_addr_o}, 64'h100);
    check("single_data", {32'd0, mem_data_o}, 64'hA5A5A5A5);
    tick();
    check("single_cnt0", {61'd0, count_o}, 64'd0);
    check("single_idle", {63'd0, mem_valid_o}, 64'd0);

    // Coalesce into a pending (non-SEND) entry
    mem_ready_i = 1'b0;
    do_push(32'h000, 32'h0, 0);
    do_push(32'h004, 32'h1, 0);
    do_push(32'h004, 32'h2, 1);
    check("coal_cnt", {61'd0, count_o}, 64'd2);
    drain();

    // Full buffer: coalesce still accepted, SEND line is not a coalesce target
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'h300 + 32'(4 * i), 32'h3000 + 32'(i), 0);
    check("cfull_cnt", {61'd0, count_o}, 64'd4);
    addr_i = 32'h308;
    #1 check("cfull_ready_match", {63'd0, ready_o}, 64'd1);
    addr_i = 32'h300;
    #1 check("cfull_ready_send", {63'd0, ready_o}, 64'd0);
    do_push(32'h308, 32'hBEEF, 1);
    check("cfull_cnt2", {61'd0, count_o}, 64'd4);
    drain();

    // Push and completion in the same cycle keep the count
    mem_ready_i = 1'b0;
    do_push(32'h200, 32'h20, 0);
    do_push(32'h204, 32'h21, 0);
    do_push(32'h208, 32'h22, 0);
    check("simul_cnt_pre", {61'd0, count_o}, 64'd3);
    mem_ready_i = 1'b1;
    do_push(32'h20C, 32'h23, 0);
    check("simul_cnt", {61'd0, count_o}, 64'd3);
    drain();
    check("no_ovf_yet", {63'd0, overflow_o}, 64'd0);

    // Fill, backpressure, overflow, back-to-back drain
    mem_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) do_push(32'(4 * i), 32'h10 + 32'(i), 0);
    check("fill_cnt", {61'd0, count_o}, 64'd4);
    addr_i = 32'h010;
    #1 check("fill_ready", {63'd0, ready_o}, 64'd0);
    do_push(32'h010, 32'h14, 2);
    check("ovf_set", {63'd0, overflow_o}, 64'd1);
    check("ovf_cnt", {61'd0, count_o}, 64'd4);
    mem_ready_i = 1'b1;
    #1 check("full_xfer_ready", {63'd0, ready_o}, 64'd0);
    wr_cyc.delete();
    drain();
    check("b2b_n", 64'(wr_cyc.size()), 64'd4);
    for (int i = 1; i < wr_cyc.size(); i++)
      check("b2b_gap", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd1);
    check("ovf_sticky", {63'd0, overflow_o}, 64'd1);

    // Push to the line being sent creates a second entry
    mem_ready_i = 1'b0;
    do_push(32'h040, 32'h1, 0);
    tick();
    check("sl_send_addr", {32'd0, mem_addr_o}, 64'h40);
    do_push(32'h040, 32'h2, 0);
    check("sl_cnt", {61'd0, count_o}, 64'd2);
    drain();

    // Lookup
    mem_ready_i = 1'b0;
    do_push(32'h080, 32'h77, 0);
    lookup_addr_i = 32'h083;
    #1 check("lk_hit", {63'd0, lookup_hit_o}, 64'd1);
    lookup_addr_i = 32'h084;
    #1 check("lk_miss", {63'd0, lookup_hit_o}, 64'd0);
    tick();
    lookup_addr_i = 32'h083;
    #1 check("lk_hit_send", {63'd0, lookup_hit_o}, 64'd1);
    drain();
    lookup_addr_i = 32'h083;
    #1 check("lk_after", {63'd0, lookup_hit_o}, 64'd0);

    // Reset mid-SEND with three entries
    mem_ready_i = 1'b0;
    do_push(32'h400, 32'h40, 0);
    do_push(32'h404, 32'h41, 0);
    do_push(32'h408, 32'h42, 0);
    check("rs_cnt", {61'd0, count_o}, 64'd3);
    check("rs_valid", {63'd0, mem_valid_o}, 64'd1);
    lookup_addr_i = 32'h400;
    arstn_i = 1'b0;
    #1;
    check_reset_outputs("midrst");
    sb.delete();
    tick();
    arstn_i = 1'b1;
    mem_ready_i = 1'b1;
    begin
      int wr0;
      wr0 = n_wr;
      repeat (10) tick();
      check("rs_no_write", 64'(n_wr - wr0), 64'd0);
    end
    check("rs_idle", {63'd0, mem_valid_o}, 64'd0);
    check("rs_cnt_after", {61'd0, count_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
